// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32x32 multiply / divide with architectural HI/LO.
// One iteration per cycle for 32 cycles (shift-add multiply, restoring divide)
// on 33-bit operand magnitudes. The signed result fix-up and the write to
// HI/LO both happen on the final iteration edge.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic        sign,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic        r_op;
  logic        r_neg_res;   // signed op whose operands differ in sign
  logic        r_neg_a;     // signed op with a negative dividend
  logic        r_dz;        // divisor was zero
  logic [32:0] r_ma;        // |a|
  logic [32:0] r_mb;        // |b|
  logic [32:0] r_acc;       // product upper half / partial remainder
  logic [31:0] r_q;         // multiplier bits / dividend bits then quotient
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;
  logic        r_done;

  logic [32:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag;
  logic [33:0] w_sum;
  logic [32:0] w_shift, w_diff, w_acc_nx;
  logic        w_ge;
  logic [31:0] w_q_nx, w_quot, w_rem, w_res_hi, w_res_lo;
  logic [63:0] w_prod, w_prod_fix;

  // Operand magnitudes on the 33-bit path, one datapath iteration, and the sign-fixed result.
  always_comb begin
    w_a_ext = sign ? {a[31], a} : {1'b0, a};
    w_b_ext = sign ? {b[31], b} : {1'b0, b};
    w_a_mag = (sign && a[31]) ? (33'd0 - w_a_ext) : w_a_ext;
    w_b_mag = (sign && b[31]) ? (33'd0 - w_b_ext) : w_b_ext;

    w_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_ma} : 34'd0);
    w_shift = {r_acc[31:0], r_q[31]};
    w_diff  = w_shift - r_mb;
    w_ge    = (w_shift >= r_mb);

    if (!r_op) begin
      w_acc_nx = w_sum[33:1];
      w_q_nx   = {w_sum[0], r_q[31:1]};
    end else if (w_ge) begin
      w_acc_nx = w_diff;
      w_q_nx   = {r_q[30:0], 1'b1};
    end else begin
      w_acc_nx = w_shift;
      w_q_nx   = {r_q[30:0], 1'b0};
    end

    w_prod     = {w_acc_nx[31:0], w_q_nx};
    w_prod_fix = r_neg_res ? (64'd0 - w_prod) : w_prod;
    // A zero divisor yields all-ones; remainder path already returns the dividend.
    if (r_dz) begin
      w_quot = 32'hFFFF_FFFF;
    end else if (r_neg_res) begin
      w_quot = 32'd0 - w_q_nx;
    end else begin
      w_quot = w_q_nx;
    end
    w_rem = r_neg_a ? (32'd0 - w_acc_nx[31:0]) : w_acc_nx[31:0];

    if (r_op) begin
      w_res_hi = w_rem;
      w_res_lo = w_quot;
    end else begin
      w_res_hi = w_prod_fix[63:32];
      w_res_lo = w_prod_fix[31:0];
    end
  end

  // Control FSM, iteration registers and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 6'd0;
      r_op      <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_a   <= 1'b0;
      r_dz      <= 1'b0;
      r_ma      <= 33'd0;
      r_mb      <= 33'd0;
      r_acc     <= 33'd0;
      r_q       <= 32'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state   <= S_BUSY;
            r_busy    <= 1'b1;
            r_cnt     <= 6'd0;
            r_op      <= op;
            r_neg_res <= sign & (a[31] ^ b[31]);
            r_neg_a   <= sign & a[31];
            r_dz      <= (b == 32'd0);
            r_ma      <= w_a_mag;
            r_mb      <= w_b_mag;
            r_acc     <= 33'd0;
            r_q       <= op ? w_a_mag[31:0] : w_b_mag[31:0];
          end else begin
            r_busy <= 1'b0;
            if (mthi) r_hi <= wdata;
            if (mtlo) r_lo <= wdata;
          end
        end
        S_BUSY: begin
          r_acc <= w_acc_nx;
          r_q   <= w_q_nx;
          if (r_cnt == 6'd31) begin
            r_state <= S_DONE;
            r_cnt   <= 6'd0;
            r_hi    <= w_res_hi;
            r_lo    <= w_res_lo;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL run on one clock and use a synchronous, active-high reset.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request a new operation; sampled only in IDLE.
REQ-005 Port: op  input  1  operation select; 0 = multiply, 1 = divide.
REQ-006 Port: sign  input  1  operand interpretation; 1 = two's-complement signed, 0 = unsigned.
REQ-007 Port: a  input  32  multiplicand or dividend.
REQ-008 Port: b  input  32  multiplier or divisor.
REQ-009 Port: mthi, mtlo  input  1 each  direct-write strobes for HI and LO.
REQ-010 Port: wdata  input  32  data for mthi/mtlo.
REQ-011 Port: busy  output  1  high while an operation is in flight; pipeline stalls on mfhi/mflo/start while high.
REQ-012 Port: done  output  1  one-cycle pulse when HI/LO take a new result.
REQ-013 Port: hi, lo  output  32 each  architectural HI/LO registers.

Function
REQ-014 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-015 IDLE->BUSY SHALL occur on the edge where start=1; a, b, op and sign SHALL be latched on that edge.
REQ-016 BUSY SHALL last exactly 32 cycles, one iteration per cycle, using a 6-bit counter from 0 to 31.
REQ-017 BUSY->DONE SHALL occur after iteration 31; DONE->IDLE SHALL occur unconditionally on the next edge.
REQ-018 hi/lo SHALL update on the BUSY->DONE edge; done SHALL be high during the DONE cycle only.
REQ-019 Start-to-done latency SHALL be 33 cycles; the next start SHALL be accepted in the cycle after DONE (in IDLE).
REQ-020 busy SHALL be 1 in BUSY and in DONE, and 0 in IDLE.
REQ-021 Multiply SHALL use iterative shift-add on operand magnitudes and produce the 64-bit product: {hi,lo} = a*b.
REQ-022 Divide SHALL use iterative restoring division on magnitudes: lo = quotient, hi = remainder.
REQ-023 For signed operations, operands SHALL be converted to magnitudes on latch and the result sign-fixed at completion.
REQ-024 Signed sign fix: product negative iff sign(a) != sign(b); quotient truncates toward zero; remainder takes the sign of the dividend.
REQ-025 Magnitude logic SHALL be 33 bits wide so that 0x80000000 negates correctly.
REQ-026 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo = 0x80000000 and hi = 0.
REQ-027 Divide by zero SHALL take the full 33 cycles and yield lo = 0xFFFFFFFF and hi = the original a.
REQ-028 start SHALL be ignored in BUSY and DONE; it is neither queued nor allowed to perturb the operation.
REQ-029 mthi/mtlo SHALL write hi/lo on the next edge only in IDLE with start=0; they SHALL be ignored otherwise.
REQ-030 If start, mthi and mtlo are asserted together in IDLE, start SHALL win and the writes SHALL be dropped.
REQ-031 hi and lo SHALL hold their value in every cycle that is not a result edge and not an accepted write.

Reset
REQ-032 When reset=1 at an edge, the block SHALL enter IDLE with hi=0, lo=0, busy=0, done=0 and the counter cleared.
REQ-033 Reset mid-operation SHALL abort the operation; no partial result SHALL reach hi/lo.
REQ-034 Reset SHALL take priority over start, mthi and mtlo.

Verification
REQ-035 Unsigned multiply: op=0, sign=0, a=0xFFFFFFFF, b=0xFFFFFFFF, start -> done at cycle 33; hi=0xFFFFFFFE, lo=0x00000001.
REQ-036 Signed multiply: op=0, sign=1, a=-3, b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; the unsigned version (sign=0) of the same operands -> hi=0x00000006, lo=0xFFFFFFEB.
REQ-037 Signed divide: op=1, sign=1, a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; overflow case 0x80000000 / -1 -> lo=0x80000000, hi=0.
REQ-038 Divide by zero: a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678, latency 33 cycles.
REQ-039 Handshake: a second start pulsed at cycles 5 and 33 -> both ignored, single done; mthi=1 while busy -> hi unchanged; mtlo with wdata=0xA5A5A5A5 in IDLE -> lo=0xA5A5A5A5 next cycle.
REQ-040 Reset at cycle 10 of a multiply -> next cycle busy=0, hi=lo=0, no done pulse; a new start then completes normally.
